// File: rtl/sha_digest_reader.sv
// sha_digest_reader
// Reads the SHA-256 digest words written by the round controller out of the
// output memory and streams them to the host over a valid/ready interface.
//
// Optional feature (macro DIGEST_READER_XSUM_EN):
//   When defined, an extra word follows the digest: the XOR of all streamed
//   digest words. out_last then marks that checksum word instead of the
//   final digest word. When undefined, the frame is exactly N_WORDS words.
//
// Output stream handshake:
//   A word transfers on a rising clk edge where out_valid && out_ready.
//   Once out_valid is high, out_data and out_last are held stable until
//   that transfer. out_valid never depends combinationally on out_ready,
//   and out_ready while out_valid is low has no effect.
//
// Memory read timing: mem_rdata is valid the cycle after mem_rd_en.
// All outputs are registered. state_dbg exposes the FSM state.

module sha_digest_reader #(
    parameter int WORD_W    = 32,
    parameter int N_WORDS   = 8,
    parameter int ADDR_W    = 4,
    parameter int ADDR_BASE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
);

    localparam int CNT_W = $clog2(N_WORDS) + 1;
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(ADDR_BASE);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N_WORDS - 1);

    // The whole digest must fit in the address space without wrapping.
    if (ADDR_BASE + N_WORDS - 1 > (2 ** ADDR_W) - 1) begin : g_addr_range_check
        $error("sha_digest_reader: ADDR_BASE+N_WORDS-1 exceeds the address range");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_SEND  = 3'd3,
        S_CSUM  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic [ADDR_W-1:0] addr_d;
    logic              rd_en_d;
    logic [WORD_W-1:0] data_d;
    logic              valid_d;
    logic              last_d;
    logic              busy_d;
    logic              done_d;
    logic              handshake;
`ifdef DIGEST_READER_XSUM_EN
    logic [WORD_W-1:0] xsum_q, xsum_d;
`endif

    assign state_dbg = state_q;
    assign handshake = out_valid && out_ready;
    assign cnt_inc   = cnt_q + CNT_W'(1);

    // State, counter and all registered outputs; reset aborts any frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef DIGEST_READER_XSUM_EN
            xsum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_addr  <= addr_d;
            mem_rd_en <= rd_en_d;
            out_data  <= data_d;
            out_valid <= valid_d;
            out_last  <= last_d;
            busy      <= busy_d;
            done      <= done_d;
`ifdef DIGEST_READER_XSUM_EN
            xsum_q    <= xsum_d;
`endif
        end
    end

    // Next-state and next-output logic. mem_rd_en is set on entry to FETCH so
    // it is high for exactly the one cycle the FSM spends in FETCH.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = mem_addr;
        rd_en_d = 1'b0;
        data_d  = out_data;
        valid_d = out_valid;
        last_d  = out_last;
        busy_d  = busy;
        done_d  = 1'b0;
`ifdef DIGEST_READER_XSUM_EN
        xsum_d  = xsum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    addr_d  = BASE_A;
                    rd_en_d = 1'b1;
                    state_d = S_FETCH;
`ifdef DIGEST_READER_XSUM_EN
                    xsum_d  = '0;
`endif
                end
            end

            S_FETCH: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                data_d  = mem_rdata;
                valid_d = 1'b1;
`ifdef DIGEST_READER_XSUM_EN
                last_d  = 1'b0;
`else
                last_d  = (cnt_q == LAST_CNT);
`endif
                state_d = S_SEND;
            end

            S_SEND: begin
                if (handshake) begin
`ifdef DIGEST_READER_XSUM_EN
                    xsum_d = xsum_q ^ out_data;
`endif
                    if (cnt_q == LAST_CNT) begin
`ifdef DIGEST_READER_XSUM_EN
                        // Checksum needs no memory read: present it next cycle.
                        data_d  = xsum_q ^ out_data;
                        valid_d = 1'b1;
                        last_d  = 1'b1;
                        state_d = S_CSUM;
`else
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
`endif
                    end else begin
                        valid_d = 1'b0;
                        cnt_d   = cnt_inc;
                        addr_d  = BASE_A + ADDR_W'(cnt_inc);
                        rd_en_d = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end

            S_CSUM: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
